// File: rtl/mod_counter.sv
// mod_counter: modulo 0..MAX up/down counter with load, enable, wrap/saturate mode and optional prescaler
// Ports:
//   c      - clock, all state changes on posedge
//   reset  - synchronous reset, active low
//   en     - count enable
//   up     - direction, 1 = increment, 0 = decrement
//   sat    - 1 = saturate at the boundary, 0 = wrap around
//   load   - parallel load strobe, d is clamped to MAX
//   d      - load value
//   o      - registered count
//   tc     - terminal count, combinational from o and up
//   wrap   - registered one-cycle pulse shown together with the wrapped value
// Build option: define MOD_COUNTER_PRESCALE_EN to step only every PRESCALE enabled cycles.
module mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX      = 8,
    parameter int PRESCALE = 1
) (
    input  logic             c,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] o,
    output logic             tc,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] max_v = WIDTH'(MAX);

    if (MAX < 1 || MAX > (2 ** WIDTH) - 1 || PRESCALE < 1) begin : g_bad_params
        $error("mod_counter: illegal WIDTH/MAX/PRESCALE");
    end

    logic             step;
    logic             boundary;
    logic [WIDTH-1:0] o_step;

`ifdef MOD_COUNTER_PRESCALE_EN
    localparam int pw = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [pw-1:0] ps_last = pw'(PRESCALE - 1);
    logic [pw-1:0] ps;
    assign step = en && (ps == ps_last);
    always_ff @(posedge c) begin
        if (!reset || load)
            ps <= '0;
        else if (en)
            ps <= (ps == ps_last) ? '0 : ps + pw'(1);
    end
`else
    assign step = en;
`endif

    // At the boundary the step either holds (sat) or jumps to the opposite end.
    always_comb begin
        boundary = up ? (o == max_v) : (o == '0);
        o_step   = boundary ? (sat ? o : (up ? '0 : max_v)) : (up ? o + WIDTH'(1) : o - WIDTH'(1));
    end

    assign tc = boundary;

    always_ff @(posedge c) begin
        if (!reset) begin
            o    <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            o    <= (d > max_v) ? max_v : d;
            wrap <= 1'b0;
        end else if (step) begin
            o    <= o_step;
            wrap <= boundary && !sat;
        end else begin
            wrap <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: self-checking bench for mod_counter using a stimulus/expectation queue
module tb_mod_counter;
    logic       c = 1'b0;
    logic       reset = 1'b0, en = 1'b0, up = 1'b1, sat = 1'b0, load = 1'b0;
    logic [3:0] d = '0;
    logic [3:0] o;
    logic       tc, wrap;
    logic [0:0] o1;
    logic       tc1, wrap1;
    int         errors = 0;
    int         checks = 0;

    typedef struct {
        logic       r, e, u, s, l;
        logic [3:0] dv;
        logic [3:0] ov;
        logic       w, t;
    } vec_t;
    vec_t q[$];
    vec_t v;

    always #5 c = ~c;

    mod_counter #(.WIDTH(4), .MAX(8), .PRESCALE(3)) dut (
        .c(c), .reset(reset), .en(en), .up(up), .sat(sat), .load(load),
        .d(d), .o(o), .tc(tc), .wrap(wrap)
    );

    mod_counter #(.WIDTH(1), .MAX(1)) dut1 (
        .c(c), .reset(reset), .en(en), .up(up), .sat(sat), .load(load),
        .d(d[0:0]), .o(o1), .tc(tc1), .wrap(wrap1)
    );

    function automatic void add(input bit r, input bit e, input bit u, input bit s, input bit l,
                                input int dv, input int ov, input bit w, input bit t);
        vec_t x;
        x.r = r; x.e = e; x.u = u; x.s = s; x.l = l;
        x.dv = 4'(dv); x.ov = 4'(ov); x.w = w; x.t = t;
        q.push_back(x);
    endfunction

    task automatic test_reset;
        add(0, 1, 1, 0, 1, 5, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0, 0);
        while (q.size() > 0) begin
            v = q.pop_front();
            reset = v.r; en = v.e; up = v.u; sat = v.s; load = v.l; d = v.dv;
            @(posedge c); #1;
            checks++;
            if (o !== v.ov || wrap !== v.w || tc !== v.t) begin
                errors++;
                $display("FAIL reset: o=%0d wrap=%b tc=%b expected o=%0d wrap=%b tc=%b", o, wrap, tc, v.ov, v.w, v.t);
            end
        end
        up = 1'b0; #1;
        checks++;
        if (tc !== 1'b1) begin
            errors++;
            $display("FAIL reset_tc_down: tc=%b expected 1", tc);
        end
    endtask

    task automatic test_up_wrap;
        for (int i = 1; i <= 8; i++) add(1, 1, 1, 0, 0, 0, i, 0, i == 8);
        add(1, 1, 1, 0, 0, 0, 0, 1, 0);
        add(1, 1, 1, 0, 0, 0, 1, 0, 0);
        while (q.size() > 0) begin
            v = q.pop_front();
            reset = v.r; en = v.e; up = v.u; sat = v.s; load = v.l; d = v.dv;
            @(posedge c); #1;
            checks++;
            if (o !== v.ov || wrap !== v.w || tc !== v.t) begin
                errors++;
                $display("FAIL up_wrap: o=%0d wrap=%b tc=%b expected o=%0d wrap=%b tc=%b", o, wrap, tc, v.ov, v.w, v.t);
            end
        end
    endtask

    task automatic test_down_wrap;
        add(1, 1, 0, 0, 1, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 8, 1, 0);
        for (int i = 7; i >= 0; i--) add(1, 1, 0, 0, 0, 0, i, 0, i == 0);
        add(1, 1, 0, 0, 0, 0, 8, 1, 0);
        while (q.size() > 0) begin
            v = q.pop_front();
            reset = v.r; en = v.e; up = v.u; sat = v.s; load = v.l; d = v.dv;
            @(posedge c); #1;
            checks++;
            if (o !== v.ov || wrap !== v.w || tc !== v.t) begin
                errors++;
                $display("FAIL down_wrap: o=%0d wrap=%b tc=%b expected o=%0d wrap=%b tc=%b", o, wrap, tc, v.ov, v.w, v.t);
            end
        end
    endtask

    task automatic test_saturate;
        add(1, 0, 1, 1, 1, 6, 6, 0, 0);
        add(1, 1, 1, 1, 0, 0, 7, 0, 0);
        add(1, 1, 1, 1, 0, 0, 8, 0, 1);
        add(1, 1, 1, 1, 0, 0, 8, 0, 1);
        add(1, 1, 1, 1, 0, 0, 8, 0, 1);
        while (q.size() > 0) begin
            v = q.pop_front();
            reset = v.r; en = v.e; up = v.u; sat = v.s; load = v.l; d = v.dv;
            @(posedge c); #1;
            checks++;
            if (o !== v.ov || wrap !== v.w || tc !== v.t) begin
                errors++;
                $display("FAIL saturate: o=%0d wrap=%b tc=%b expected o=%0d wrap=%b tc=%b", o, wrap, tc, v.ov, v.w, v.t);
            end
        end
        up = 1'b0; #1;
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("FAIL saturate_tc_follow_up: tc=%b expected 0", tc);
        end
        add(1, 1, 0, 1, 0, 0, 7, 0, 0);
        add(1, 1, 0, 0, 0, 0, 6, 0, 0);
        while (q.size() > 0) begin
            v = q.pop_front();
            reset = v.r; en = v.e; up = v.u; sat = v.s; load = v.l; d = v.dv;
            @(posedge c); #1;
            checks++;
            if (o !== v.ov || wrap !== v.w || tc !== v.t) begin
                errors++;
                $display("FAIL saturate_down: o=%0d wrap=%b tc=%b expected o=%0d wrap=%b tc=%b", o, wrap, tc, v.ov, v.w, v.t);
            end
        end
    endtask

    task automatic test_load;
        add(1, 0, 1, 0, 1, 13, 8, 0, 1);
        add(1, 1, 1, 0, 1, 5, 5, 0, 0);
        add(1, 0, 1, 0, 0, 0, 5, 0, 0);
        add(1, 0, 0, 0, 0, 0, 5, 0, 0);
        add(1, 0, 1, 0, 0, 0, 5, 0, 0);
        add(1, 1, 1, 0, 1, 15, 8, 0, 1);
        add(1, 1, 1, 0, 0, 0, 0, 1, 0);
        while (q.size() > 0) begin
            v = q.pop_front();
            reset = v.r; en = v.e; up = v.u; sat = v.s; load = v.l; d = v.dv;
            @(posedge c); #1;
            checks++;
            if (o !== v.ov || wrap !== v.w || tc !== v.t) begin
                errors++;
                $display("FAIL load: o=%0d wrap=%b tc=%b expected o=%0d wrap=%b tc=%b", o, wrap, tc, v.ov, v.w, v.t);
            end
        end
    endtask

    task automatic test_reset_priority;
        add(1, 0, 1, 0, 1, 6, 6, 0, 0);
        add(0, 1, 1, 0, 1, 3, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 1, 0, 0);
        add(1, 1, 1, 0, 0, 0, 2, 0, 0);
        add(1, 1, 1, 0, 0, 0, 3, 0, 0);
        add(1, 0, 1, 0, 1, 8, 8, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0, 0, 0);
        while (q.size() > 0) begin
            v = q.pop_front();
            reset = v.r; en = v.e; up = v.u; sat = v.s; load = v.l; d = v.dv;
            @(posedge c); #1;
            checks++;
            if (o !== v.ov || wrap !== v.w || tc !== v.t) begin
                errors++;
                $display("FAIL reset_priority: o=%0d wrap=%b tc=%b expected o=%0d wrap=%b tc=%b", o, wrap, tc, v.ov, v.w, v.t);
            end
        end
    endtask

    // Second instance: WIDTH=1, MAX=1, so MAX is also the full-scale value.
    task automatic test_back_to_back;
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 1, 0, 1);
        add(1, 1, 1, 0, 0, 0, 0, 1, 0);
        add(1, 1, 1, 0, 0, 0, 1, 0, 1);
        add(1, 1, 0, 0, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 1, 1, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 1, 1, 0);
        add(1, 1, 1, 1, 0, 0, 1, 0, 1);
        add(1, 0, 1, 0, 1, 1, 1, 0, 1);
        while (q.size() > 0) begin
            v = q.pop_front();
            reset = v.r; en = v.e; up = v.u; sat = v.s; load = v.l; d = v.dv;
            @(posedge c); #1;
            checks++;
            if ({3'b000, o1} !== v.ov || wrap1 !== v.w || tc1 !== v.t) begin
                errors++;
                $display("FAIL back_to_back: o=%0d wrap=%b tc=%b expected o=%0d wrap=%b tc=%b", o1, wrap1, tc1, v.ov, v.w, v.t);
            end
        end
    endtask

`ifdef MOD_COUNTER_PRESCALE_EN
    task automatic test_prescale;
        add(0, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 1, 0, 0);
        add(1, 1, 1, 0, 0, 0, 1, 0, 0);
        add(1, 1, 1, 0, 0, 0, 1, 0, 0);
        add(1, 1, 1, 0, 0, 0, 2, 0, 0);
        add(1, 1, 1, 0, 0, 0, 2, 0, 0);
        add(1, 0, 1, 0, 0, 0, 2, 0, 0);
        add(1, 0, 1, 0, 0, 0, 2, 0, 0);
        add(1, 1, 1, 0, 0, 0, 2, 0, 0);
        add(1, 1, 1, 0, 0, 0, 3, 0, 0);
        add(1, 1, 1, 0, 0, 0, 3, 0, 0);
        add(1, 1, 1, 0, 1, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 1, 0, 0);
        while (q.size() > 0) begin
            v = q.pop_front();
            reset = v.r; en = v.e; up = v.u; sat = v.s; load = v.l; d = v.dv;
            @(posedge c); #1;
            checks++;
            if (o !== v.ov || wrap !== v.w || tc !== v.t) begin
                errors++;
                $display("FAIL prescale: o=%0d wrap=%b tc=%b expected o=%0d wrap=%b tc=%b", o, wrap, tc, v.ov, v.w, v.t);
            end
        end
    endtask
`endif

    initial begin
`ifdef MOD_COUNTER_PRESCALE_EN
        test_prescale();
`else
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_saturate();
        test_load();
        test_reset_priority();
        test_back_to_back();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
